bt_cmd_rx: RTL

//  Upstream control stage of the MP3 player: receives bytes from the Bluetooth UART module,

---
 rtl/mp3_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 118 +++++++++++
 rtl/bt_cmd_rx.sv | 71 +++++++
 3 files changed

// File: rtl/mp3_pkg.sv
// Shared command codes, default track count and receiver state encoding
// for the Bluetooth command path of the MP3 player.
package mp3_pkg;

    localparam logic [7:0] CMD_NEXT     = 8'h01;
    localparam logic [7:0] CMD_PREV     = 8'h02;
    localparam logic [7:0] CMD_VUP      = 8'h03;
    localparam logic [7:0] CMD_VDN      = 8'h04;
    localparam logic [7:0] CMD_SEL_BASE = 8'h10;

    localparam int TRACKS_DEF = 7;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchroniser, mid-bit sampling,
// one-cycle valid / frame-error strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle high, waiting for a falling edge
// RX_START | counting to mid start bit to reject glitches
// RX_DATA  | sampling 8 data bits LSB first, one per bit time
// RX_STOP  | sampling the stop bit; high = good byte, low = frame error
// RX_BREAK | line held low after a bad stop bit; wait for it to go high
module uart_rx_byte
    import mp3_pkg::*;
#(
    parameter int BIT_CYC = 10416
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int          HALF      = BIT_CYC / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    logic        sync_1;
    logic        sync_2;
    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  bitn;
    logic [2:0]  bitn_nxt;
    logic [7:0]  shift;
    logic [7:0]  shift_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt;
    logic        ferr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_1     <= rxd;
            sync_2     <= sync_1;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bitn       <= bitn_nxt;
            shift      <= shift_nxt;
            byte_data  <= data_nxt;
            byte_valid <= valid_nxt;
            frame_err  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        bitn_nxt  = bitn;
        shift_nxt = shift;
        data_nxt  = byte_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_nxt = '0;
                if (!sync_2) state_nxt = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    bitn_nxt  = '0;
                    state_nxt = sync_2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {sync_2, shift[7:1]};
                    bitn_nxt  = bitn + 3'd1;
                    if (bitn == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (sync_2) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = RX_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_nxt = '0;
                if (sync_2) state_nxt = RX_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bt_cmd_rx.sv
// Bluetooth command receiver: UART byte reception plus registered command
// decode that owns the current track index and drives volume strobes.
module bt_cmd_rx
    import mp3_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int TRACKS = TRACKS_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RXD,
    output logic [2:0] track,
    output logic       vol_up,
    output logic       vol_down,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int         BIT_CYC  = CLK_HZ / BAUD;
    localparam logic [2:0] TRK_LAST = 3'(TRACKS - 1);
    localparam logic [3:0] TRK_NUM  = 4'(TRACKS);

    logic [2:0] track_nxt;
    logic       up_nxt;
    logic       dn_nxt;

    uart_rx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .clk        (CLK),
        .rst_b      (RST),
        .rxd        (UART_RXD),
        .byte_data  (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (frame_err)
    );

    // rx_data is registered alongside rx_valid, so it already holds the new byte here.
    always_comb begin
        track_nxt = track;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        if (rx_valid) begin
            case (rx_data)
                CMD_NEXT: track_nxt = (track == TRK_LAST) ? 3'd0 : track + 3'd1;
                CMD_PREV: track_nxt = (track == 3'd0) ? TRK_LAST : track - 3'd1;
                CMD_VUP:  up_nxt    = 1'b1;
                CMD_VDN:  dn_nxt    = 1'b1;
                default: begin
                    if (rx_data[7:4] == CMD_SEL_BASE[7:4] && rx_data[3:0] < TRK_NUM)
                        track_nxt = rx_data[2:0];
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            track    <= '0;
            vol_up   <= 1'b0;
            vol_down <= 1'b0;
        end else begin
            track    <= track_nxt;
            vol_up   <= up_nxt;
            vol_down <= dn_nxt;
        end
    end

endmodule
